// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and default address map for the data-memory request demux
package dmem_pkg;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_IO   = 2'd2
  } tgt_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } demux_state_t;

  typedef enum logic [1:0] {
    DEC_OK         = 2'd0,
    DEC_MISALIGNED = 2'd1,
    DEC_UNMAPPED   = 2'd2
  } dec_err_t;

  localparam logic [31:0] DMEM_IO_BASE   = 32'h1000_0000;
  localparam logic [31:0] DMEM_IO_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] DMEM_RAM_LIMIT = 32'h0001_0000;

endpackage

// File: rtl/dmem_req_demux_if.sv
// rtl/dmem_req_demux_if.sv - upstream request/response and per-target bus bundle for dmem_req_demux
interface dmem_req_demux_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_wstrb;

  logic                resp_valid;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;

  logic                ram_valid;
  logic                io_valid;
  logic                ram_ready;
  logic                io_ready;

  logic                tgt_we;
  logic [ADDR_W-1:0]   tgt_addr;
  logic [DATA_W-1:0]   tgt_wdata;
  logic [DATA_W/8-1:0] tgt_wstrb;

  logic                ram_rvalid;
  logic                io_rvalid;
  logic [DATA_W-1:0]   ram_rdata;
  logic [DATA_W-1:0]   io_rdata;

  // Environment side: the core plus both targets.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_valid, io_valid, tgt_we, tgt_addr, tgt_wdata, tgt_wstrb,
    output ram_ready, io_ready, ram_rvalid, io_rvalid, ram_rdata, io_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_valid, io_valid, tgt_we, tgt_addr, tgt_wdata, tgt_wstrb,
    input  ram_ready, io_ready, ram_rvalid, io_rvalid, ram_rdata, io_rdata
  );

endinterface

// File: rtl/dmem_addr_decode.sv
// rtl/dmem_addr_decode.sv - combinational address decode to target select and error class
module dmem_addr_decode
  import dmem_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] IO_BASE   = ADDR_W'(DMEM_IO_BASE),
  parameter logic [ADDR_W-1:0] IO_MASK   = ADDR_W'(DMEM_IO_MASK),
  parameter logic [ADDR_W-1:0] RAM_LIMIT = ADDR_W'(DMEM_RAM_LIMIT)
) (
  input  logic [ADDR_W-1:0] addr,
  output tgt_sel_t          sel,
  output dec_err_t          err
);

  // IO is tested before RAM so an overlapping MMIO window shadows RAM.
  always_comb begin
    sel = SEL_NONE;
    err = DEC_OK;
    if (addr[1:0] != 2'b00) begin
      err = DEC_MISALIGNED;
    end else if ((addr & IO_MASK) == IO_BASE) begin
      sel = SEL_IO;
    end else if (addr < RAM_LIMIT) begin
      sel = SEL_RAM;
    end else begin
      err = DEC_UNMAPPED;
    end
  end

endmodule

// File: rtl/dmem_req_demux.sv
// rtl/dmem_req_demux.sv - one-outstanding data-memory request demux to RAM/MMIO; DMEM_REQ_DEMUX_TIMEOUT_EN adds a response timeout
module dmem_req_demux
  import dmem_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] IO_BASE        = ADDR_W'(DMEM_IO_BASE),
  parameter logic [ADDR_W-1:0] IO_MASK        = ADDR_W'(DMEM_IO_MASK),
  parameter logic [ADDR_W-1:0] RAM_LIMIT      = ADDR_W'(DMEM_RAM_LIMIT),
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  dmem_req_demux_if.slave  bus
);

  if ((DATA_W % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("dmem_req_demux: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  tgt_sel_t     dec_sel;
  dec_err_t     dec_err;
  demux_state_t state;
  tgt_sel_t     sel;
  logic         we_q;
  logic         resp_valid_q;
  logic         resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic              is_err;
  logic              req_ready_c;
  logic              accept;
  logic              sel_rvalid;
  logic [DATA_W-1:0] sel_rdata;

  dmem_addr_decode #(
    .ADDR_W    (ADDR_W),
    .IO_BASE   (IO_BASE),
    .IO_MASK   (IO_MASK),
    .RAM_LIMIT (RAM_LIMIT)
  ) u_decode (
    .addr (bus.req_addr),
    .sel  (dec_sel),
    .err  (dec_err)
  );

  assign is_err = (dec_err != DEC_OK);

  always_comb begin
    req_ready_c = 1'b0;
    if (state == ST_IDLE) begin
      case (dec_sel)
        SEL_RAM: req_ready_c = bus.ram_ready;
        SEL_IO:  req_ready_c = bus.io_ready;
        default: req_ready_c = 1'b1;
      endcase
    end
  end

  assign accept        = bus.req_valid & req_ready_c;
  assign bus.req_ready = req_ready_c;
  assign bus.ram_valid = (state == ST_IDLE) & bus.req_valid & (dec_sel == SEL_RAM);
  assign bus.io_valid  = (state == ST_IDLE) & bus.req_valid & (dec_sel == SEL_IO);

  // Payload is a straight pass-through; the requester holds it stable until accepted.
  assign bus.tgt_we    = bus.req_we;
  assign bus.tgt_addr  = bus.req_addr;
  assign bus.tgt_wdata = bus.req_wdata;
  assign bus.tgt_wstrb = bus.req_wstrb;

  // Only the latched target may complete a transaction; the other rvalid is dropped.
  always_comb begin
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    case (sel)
      SEL_RAM: begin
        sel_rvalid = bus.ram_rvalid;
        sel_rdata  = bus.ram_rdata;
      end
      SEL_IO: begin
        sel_rvalid = bus.io_rvalid;
        sel_rdata  = bus.io_rdata;
      end
      default: ;
    endcase
  end

`ifdef DMEM_REQ_DEMUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      sel          <= SEL_NONE;
      we_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
`ifdef DMEM_REQ_DEMUX_TIMEOUT_EN
      cnt          <= '0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_err) begin
              state        <= ST_ERR;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state <= ST_WAIT;
              sel   <= dec_sel;
              we_q  <= bus.req_we;
`ifdef DMEM_REQ_DEMUX_TIMEOUT_EN
              cnt   <= '0;
`endif
            end
          end
        end
        ST_WAIT: begin
          if (sel_rvalid) begin
            state        <= ST_IDLE;
            sel          <= SEL_NONE;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= we_q ? '0 : sel_rdata;
          end
`ifdef DMEM_REQ_DEMUX_TIMEOUT_EN
          // A response in the limit cycle takes the branch above and wins.
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state        <= ST_ERR;
            sel          <= SEL_NONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            cnt          <= CNT_W'(TIMEOUT_CYCLES);
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_ERR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          sel   <= SEL_NONE;
        end
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_req_demux.sv
// tb/tb_dmem_req_demux.sv - directed self-checking bench for dmem_req_demux; timeout cases under DMEM_REQ_DEMUX_TIMEOUT_EN
module tb_dmem_req_demux;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dmem_req_demux_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_req_demux #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .IO_BASE        (32'h1000_0000),
    .IO_MASK        (32'hFFFF_0000),
    .RAM_LIMIT      (32'h0001_0000),
`ifdef DMEM_REQ_DEMUX_TIMEOUT_EN
    .TIMEOUT_CYCLES (8)
`else
    .TIMEOUT_CYCLES (255)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_wstrb  = '0;
    bus.ram_ready  = 1'b0;
    bus.io_ready   = 1'b0;
    bus.ram_rvalid = 1'b0;
    bus.io_rvalid  = 1'b0;
    bus.ram_rdata  = '0;
    bus.io_rdata   = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] err_addrs [3];

  initial begin
    checks   = 0;
    failures = 0;
    err_addrs[0] = 32'h0000_0042;
    err_addrs[1] = 32'h2000_0000;
    err_addrs[2] = 32'h0001_0000;
    idle_inputs();
    rst = 1'b1;
    #3;
    check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err", 32'(bus.resp_err), 32'h0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // RAM read, rvalid two cycles after acceptance
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0040;
    bus.ram_ready = 1'b1;
    settle();
    check("rd_ram_valid", 32'(bus.ram_valid), 32'h1);
    check("rd_io_valid", 32'(bus.io_valid), 32'h0);
    check("rd_req_ready", 32'(bus.req_ready), 32'h1);
    cyc();
    bus.req_valid = 1'b0;
    bus.ram_ready = 1'b0;
    settle();
    check("rd_wait_ready", 32'(bus.req_ready), 32'h0);
    cyc();
    bus.ram_rvalid = 1'b1;
    bus.ram_rdata  = 32'hDEAD_BEEF;
    settle();
    check("rd_no_early_resp", 32'(bus.resp_valid), 32'h0);
    cyc();
    bus.ram_rvalid = 1'b0;
    settle();
    check("rd_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("rd_resp_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
    check("rd_resp_err", 32'(bus.resp_err), 32'h0);
    cyc();
    settle();
    check("rd_resp_single", 32'(bus.resp_valid), 32'h0);
    cyc();

    // IO write stalled by io_ready for three cycles
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h1000_0004;
    bus.req_wdata = 32'h0000_00A5;
    bus.req_wstrb = 4'h1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("wr_stall_ready", 32'(bus.req_ready), 32'h0);
      check("wr_stall_io_valid", 32'(bus.io_valid), 32'h1);
      check("wr_stall_ram_valid", 32'(bus.ram_valid), 32'h0);
      cyc();
    end
    bus.io_ready = 1'b1;
    settle();
    check("wr_ready", 32'(bus.req_ready), 32'h1);
    check("wr_tgt_addr", bus.tgt_addr, 32'h1000_0004);
    check("wr_tgt_wdata", bus.tgt_wdata, 32'h0000_00A5);
    check("wr_tgt_wstrb", 32'(bus.tgt_wstrb), 32'h1);
    check("wr_tgt_we", 32'(bus.tgt_we), 32'h1);
    cyc();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.io_ready  = 1'b0;
    bus.io_rvalid = 1'b1;
    bus.io_rdata  = 32'h1234_5678;
    cyc();
    bus.io_rvalid = 1'b0;
    settle();
    check("wr_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("wr_resp_rdata", bus.resp_rdata, 32'h0);
    check("wr_resp_err", 32'(bus.resp_err), 32'h0);
    cyc();

    // RAM upper boundary still decodes to RAM
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_FFFC;
    settle();
    check("bnd_ram_valid", 32'(bus.ram_valid), 32'h1);
    check("bnd_req_ready", 32'(bus.req_ready), 32'h0);
    bus.req_valid = 1'b0;
    cyc();

    // Misaligned and unmapped requests are answered internally
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = err_addrs[i];
      settle();
      check("err_ram_valid", 32'(bus.ram_valid), 32'h0);
      check("err_io_valid", 32'(bus.io_valid), 32'h0);
      check("err_req_ready", 32'(bus.req_ready), 32'h1);
      check("err_no_early_resp", 32'(bus.resp_valid), 32'h0);
      cyc();
      bus.req_valid = 1'b0;
      settle();
      check("err_resp_valid", 32'(bus.resp_valid), 32'h1);
      check("err_resp_err", 32'(bus.resp_err), 32'h1);
      check("err_resp_rdata", bus.resp_rdata, 32'h0);
      cyc();
      settle();
      check("err_resp_single", 32'(bus.resp_valid), 32'h0);
      cyc();
    end

    // Steering: io_rvalid ignored while waiting on RAM
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0100;
    bus.ram_ready = 1'b1;
    cyc();
    bus.req_valid = 1'b0;
    bus.ram_ready = 1'b0;
    bus.io_rvalid = 1'b1;
    bus.io_rdata  = 32'h1111_1111;
    cyc();
    bus.io_rvalid = 1'b0;
    settle();
    check("steer_ignore_io", 32'(bus.resp_valid), 32'h0);
    bus.ram_rvalid = 1'b1;
    bus.ram_rdata  = 32'h2222_2222;
    cyc();
    bus.ram_rvalid = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h0000_0200;
    bus.ram_ready  = 1'b1;
    settle();
    check("steer_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("steer_resp_rdata", bus.resp_rdata, 32'h2222_2222);
    check("b2b_req_ready", 32'(bus.req_ready), 32'h1);
    cyc();
    bus.req_valid = 1'b0;
    bus.ram_ready = 1'b0;
    settle();
    check("b2b_resp_single", 32'(bus.resp_valid), 32'h0);
    check("b2b_in_wait", 32'(bus.req_ready), 32'h0);

    // Reset mid-WAIT, then a stray rvalid
    rst = 1'b1;
    settle();
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("mid_rst_resp_rdata", bus.resp_rdata, 32'h0);
    cyc();
    rst = 1'b0;
    bus.ram_rvalid = 1'b1;
    bus.ram_rdata  = 32'h3333_3333;
    cyc();
    bus.ram_rvalid = 1'b0;
    settle();
    check("stray_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("stray_resp_rdata", bus.resp_rdata, 32'h0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1000_0008;
    bus.io_ready  = 1'b1;
    settle();
    check("post_rst_io_valid", 32'(bus.io_valid), 32'h1);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'h1);
    cyc();
    bus.req_valid = 1'b0;
    bus.io_ready  = 1'b0;
    bus.io_rvalid = 1'b1;
    bus.io_rdata  = 32'hCAFE_0001;
    cyc();
    bus.io_rvalid = 1'b0;
    settle();
    check("post_rst_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("post_rst_resp_rdata", bus.resp_rdata, 32'hCAFE_0001);
    check("post_rst_resp_err", 32'(bus.resp_err), 32'h0);
    cyc();

`ifdef DMEM_REQ_DEMUX_TIMEOUT_EN
    // Target never answers: error after eight WAIT cycles
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0300;
    bus.ram_ready = 1'b1;
    cyc();
    bus.req_valid = 1'b0;
    bus.ram_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("to_no_resp", 32'(bus.resp_valid), 32'h0);
      cyc();
    end
    settle();
    check("to_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("to_resp_err", 32'(bus.resp_err), 32'h1);
    cyc();
    settle();
    check("to_resp_single", 32'(bus.resp_valid), 32'h0);
    cyc();

    // Response in the limit cycle wins over the timeout
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0304;
    bus.ram_ready = 1'b1;
    cyc();
    bus.req_valid = 1'b0;
    bus.ram_ready = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    bus.ram_rvalid = 1'b1;
    bus.ram_rdata  = 32'h0000_0055;
    cyc();
    bus.ram_rvalid = 1'b0;
    settle();
    check("to_edge_resp_valid", 32'(bus.resp_valid), 32'h1);
    check("to_edge_resp_err", 32'(bus.resp_err), 32'h0);
    check("to_edge_resp_rdata", bus.resp_rdata, 32'h0000_0055);
    cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_req_demux.md
Name: dmem_req_demux

Overview:
- Routes one data-memory request stream from the single-cycle core to one of two targets, data RAM or the MMIO peripheral block, selected by address decode.
- It is the demultiplexing counterpart of the datapath 2:1 result mux: one source fans out to N sinks, and the read response is steered back to the single source.
- Holds one outstanding transaction.
- Generates error responses internally for undecodable or misaligned requests.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, data width (multiple of 8)
- IO_BASE, 32'h1000_0000, MMIO region base
- IO_MASK, 32'hFFFF_0000, a request is MMIO when (req_addr & IO_MASK) == IO_BASE
- RAM_LIMIT, 32'h0001_0000, a request is RAM when req_addr < RAM_LIMIT
- TIMEOUT_CYCLES, 255, response wait limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  upstream request valid
- req_ready  out  1  upstream request accepted this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  byte enables
- resp_valid  out  1  single-cycle response pulse
- resp_rdata  out  DATA_W  read data (0 for writes and errors)
- resp_err  out  1  error flag, qualified by resp_valid
- ram_valid, io_valid  out  1  per-target request valid
- ram_ready, io_ready  in  1  per-target request ready
- tgt_we, tgt_addr, tgt_wdata, tgt_wstrb  out  as req_*  shared request payload, passed through to both targets
- ram_rvalid, io_rvalid  in  1  per-target response valid
- ram_rdata, io_rdata  in  DATA_W  per-target response data

Behaviour:
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, sel=NONE, timeout counter=0.
- Decode: MISALIGNED if req_addr[1:0] != 0. Otherwise IO if the mask matches; otherwise RAM if req_addr < RAM_LIMIT; otherwise UNMAPPED.
- IO takes priority over RAM if the regions overlap.
- State IDLE:
  - ram_valid = req_valid & dec==RAM; io_valid = req_valid & dec==IO.
  - req_ready = ram_ready for RAM, io_ready for IO, 1 for MISALIGNED/UNMAPPED.
  - On handshake to a target: latch sel, go to WAIT.
  - On handshake for an error decode: go to ERR.
- State WAIT:
  - req_ready=0; ram_valid=0; io_valid=0.
  - When the selected target's rvalid is 1: register its rdata into resp_rdata, pulse resp_valid with resp_err=0, go to IDLE.
  - rvalid from the non-selected target is ignored.
- State ERR: resp_valid=1, resp_err=1, resp_rdata=0 for one cycle, then IDLE.
- Latency: response appears exactly 1 cycle after the target's rvalid. Error response appears 1 cycle after request acceptance.
- Writes receive a response like reads; the target returns rvalid as an ack and resp_rdata is forced to 0.
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high, because the state is already IDLE.
- resp_valid is high for one cycle per accepted request, never more. There is no response backpressure.
- rvalid from either target while in IDLE (stray) is ignored and produces no resp_valid.
- Reset asserted mid-WAIT:
  - Immediate return to IDLE with outputs cleared.
  - The outstanding response is discarded.
  - A late rvalid after reset is treated as stray.
- Request payload must be held stable while req_valid=1 and req_ready=0. The block does not register it.

Optional Feature:
- Macro DMEM_REQ_DEMUX_TIMEOUT_EN.
- Defined:
  - A counter is cleared on WAIT entry and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without the selected rvalid, the block goes to ERR (resp_err=1) and then IDLE.
  - A response arriving in the same cycle the counter reaches the limit wins: normal response, no error.
- Undefined: no counter; WAIT persists until rvalid or reset.

Decomposition:
- Shared package dmem_pkg holds:
  - typedef tgt_sel_t {SEL_NONE, SEL_RAM, SEL_IO}
  - typedef demux_state_t {ST_IDLE, ST_WAIT, ST_ERR}
  - default IO_BASE, IO_MASK and RAM_LIMIT constants
- One natural sub-module: dmem_addr_decode. It is purely combinational, maps addr to tgt_sel_t plus an error class, and is reused by the core's load/store unit checks.

Test Plan:
- RAM read: addr 0x0000_0040, ram_ready=1, ram_rvalid 2 cycles later with 0xDEADBEEF -> ram_valid only, resp_valid 1 cycle after rvalid, rdata 0xDEADBEEF, err 0.
- IO write: addr 0x1000_0004, wdata 0x0000_00A5, wstrb 0x1, io_ready low 3 cycles -> req_ready low 3 cycles, io_valid held, resp_rdata 0 / err 0 after io ack.
- Errors: addr 0x0000_0042 and addr 0x2000_0000 -> neither target valid, req_ready=1, resp_valid+resp_err exactly 1 cycle after acceptance, rdata 0.
- Steering: in WAIT on RAM, io_rvalid pulses with 0x1111_1111, then ram_rvalid with 0x2222_2222 -> single response 0x2222_2222.
- Reset mid-WAIT, then a stray ram_rvalid -> outputs 0, no resp_valid; the next request is accepted normally.
- With DMEM_REQ_DEMUX_TIMEOUT_EN, TIMEOUT_CYCLES=8, target never responds -> resp_err pulse after 8 WAIT cycles; a response at cycle 8 -> normal response, no error.
